serial_parallel: RTL

Serial-to-parallel receiver for the single-wire bus framing used by `parallel_serial`. It watches the shared serial line, detects the low start bit, and shifts in `bit_length` data bits LSB first. It then presents the assembled word on a parallel port with a one-cycle valid pulse. It sits at every bus endpoint that consumes serial frames: masters receiving read data, and slaves receiving address, command or write data.

---
 rtl/serial_parallel_pkg.sv | 13 +
 rtl/serial_parallel_serial_in_sync.sv | 33 +++
 rtl/serial_parallel.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_parallel_pkg.sv
// Shared definitions for the single-wire serial bus framing (receiver and transmitter).
// FSM state encodings and the line level that marks a start bit.
package serial_parallel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_STOP    = 2'd2
  } state_t;

  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/serial_parallel_serial_in_sync.sv
// Two-flop synchronizer for the serial line; anything other than a solid 0
// (1, Z, X) enters as 1, and both flops reset to the idle level 1.
module serial_in_sync
  import serial_parallel_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic din_sync
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = 1'b1;
    if (din == LINE_START) s1_d = 1'b0;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign din_sync = s2_q;

endmodule

// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver: start bit, bit_length data bits LSB first, one STOP cycle.
// Define SERIAL_PARALLEL_SYNC_EN to put a two-flop synchronizer in front of the FSM.
module serial_parallel
  import serial_parallel_pkg::*;
#(
  parameter int PARALLEL_PORT_WIDTH = 15,
  parameter int BIT_LENGTH          = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           din,
  input  logic [BIT_LENGTH-1:0]          bit_length,
  output logic [PARALLEL_PORT_WIDTH-1:0] dout,
  output logic                           dv_out,
  output logic                           busy,
  output logic                           frame_err
);

  logic din_fsm;

`ifdef SERIAL_PARALLEL_SYNC_EN
  serial_in_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .din      (din),
    .din_sync (din_fsm)
  );
`else
  assign din_fsm = din;
`endif

  state_t                         state_q, state_d;
  logic [BIT_LENGTH-1:0]          cnt_q, cnt_d;
  logic [BIT_LENGTH-1:0]          len_q, len_d;
  logic [PARALLEL_PORT_WIDTH-1:0] shift_q, shift_d;
  logic [PARALLEL_PORT_WIDTH-1:0] dout_q, dout_d;
  logic                           dv_q, dv_d;
  logic                           busy_q, busy_d;
  logic                           ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    busy_d  = busy_q;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // X/Z compare false here, so only a solid 0 starts a frame.
        if (din_fsm == LINE_START) begin
          len_d   = bit_length;
          cnt_d   = '0;
          shift_d = '0;
          busy_d  = 1'b1;
          state_d = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (int'(cnt_q) < PARALLEL_PORT_WIDTH) shift_d[cnt_q] = din_fsm;
        cnt_d = cnt_q + 1'b1;
        // len_q of 0 wraps to 2^BIT_LENGTH bits; the buffer was cleared at
        // start, so positions at and above len_q are already zero.
        if (cnt_q == len_q - 1'b1) begin
          dout_d  = shift_d;
          dv_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (din_fsm == LINE_START) ferr_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign dout      = dout_q;
  assign dv_out    = dv_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

endmodule
